// File: rtl/mdu_pkg.sv
// Shared opcode encodings and default latencies for the multiply/divide unit.
package mdu_pkg;
  localparam int MD_OP_W         = 3;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;
endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage <-> MDU bundle: operation request, D-stage hazard hint, status and HI/LO.
interface mdu_ctrl_if;
  import mdu_pkg::*;

  logic               start;
  logic [MD_OP_W-1:0] md_op;
  logic [31:0]        rs_val;
  logic [31:0]        rt_val;
  logic               md_use_d;
  logic               busy;
  logic               md_stall;
  logic [31:0]        hi;
  logic [31:0]        lo;

  modport master (
    output start, md_op, rs_val, rt_val, md_use_d,
    input  busy, md_stall, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, md_use_d,
    output busy, md_stall, hi, lo
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath; no state, results valid the same cycle.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [MD_OP_W-1:0] md_op_i,
  input  logic [31:0]        rs_val_i,
  input  logic [31:0]        rt_val_i,
  output logic [31:0]        res_hi_o,
  output logic [31:0]        res_lo_o,
  output logic               div_zero_o
);
  logic [63:0] prod_s, prod_u;
  logic        sgn_div, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  assign prod_s = {{32{rs_val_i[31]}}, rs_val_i} * {{32{rt_val_i[31]}}, rt_val_i};
  assign prod_u = {32'd0, rs_val_i} * {32'd0, rt_val_i};

  // Magnitude divide; 0x80000000 negates to itself, which is exactly 2^31 unsigned,
  // so MIN/-1 falls out as quotient 0x80000000, remainder 0 without a special case.
  assign sgn_div = (md_op_i == MD_DIV);
  assign a_neg   = sgn_div & rs_val_i[31];
  assign b_neg   = sgn_div & rt_val_i[31];
  assign a_mag   = a_neg ? -rs_val_i : rs_val_i;
  assign b_mag   = b_neg ? -rt_val_i : rt_val_i;
  assign b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag   = a_mag / b_safe;
  assign r_mag   = a_mag % b_safe;
  assign quot    = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem     = a_neg ? -r_mag : r_mag;

  assign div_zero_o = ((md_op_i == MD_DIV) || (md_op_i == MD_DIVU)) && (rt_val_i == 32'd0);

  always_comb begin
    res_hi_o = 32'd0;
    res_lo_o = 32'd0;
    case (md_op_e'(md_op_i))
      MD_MULT:         {res_hi_o, res_lo_o} = prod_s;
      MD_MULTU:        {res_hi_o, res_lo_o} = prod_u;
      MD_DIV, MD_DIVU: begin
        res_hi_o = rem;
        res_lo_o = quot;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: fixed-latency busy counter, pending result, HI/LO and D-stage stall.
// Results land MULT_CYCLES/DIV_CYCLES edges after start; new starts while busy are dropped.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  bus
);
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      p_hi_q, p_hi_d, p_lo_q, p_lo_d;
  logic             p_wr_q, p_wr_d;
  logic [31:0]      res_hi, res_lo;
  logic             div_zero;

  mdu_arith u_arith (
    .md_op_i    (bus.md_op),
    .rs_val_i   (bus.rs_val),
    .rt_val_i   (bus.rt_val),
    .res_hi_o   (res_hi),
    .res_lo_o   (res_lo),
    .div_zero_o (div_zero)
  );

  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    p_hi_d = p_hi_q;
    p_lo_d = p_lo_q;
    p_wr_d = p_wr_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && p_wr_q) begin
        hi_d = p_hi_q;
        lo_d = p_lo_q;
      end
    end else if (bus.start) begin
      case (md_op_e'(bus.md_op))
        MD_MULT, MD_MULTU: begin
          p_hi_d = res_hi;
          p_lo_d = res_lo;
          p_wr_d = 1'b1;
          cnt_d  = CNT_W'(MULT_CYCLES);
        end
        MD_DIV, MD_DIVU: begin
          // Divide-by-zero still occupies the unit but must leave HI/LO untouched.
          p_hi_d = res_hi;
          p_lo_d = res_lo;
          p_wr_d = ~div_zero;
          cnt_d  = CNT_W'(DIV_CYCLES);
        end
        MD_MTHI: hi_d = bus.rs_val;
        MD_MTLO: lo_d = bus.rs_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      p_hi_q <= 32'd0;
      p_lo_q <= 32'd0;
      p_wr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      p_hi_q <= p_hi_d;
      p_lo_q <= p_lo_d;
      p_wr_q <= p_wr_d;
    end
  end

  assign bus.busy     = (cnt_q != '0);
  assign bus.md_stall = (bus.start | bus.busy) & bus.md_use_d;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: expected HI/LO queued at issue, compared when busy falls.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];

  mdu_ctrl_if bus();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input string tag, input int n_exp,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int   n;
    exp_t e;
    sb.push_back('{tag, ehi, elo});
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = rs;
    bus.rt_val = rt;
    tick();
    bus.start = 1'b0;
    bus.md_op = 3'd0;
    n = 0;
    while (bus.busy && n < 64) begin
      n++;
      tick();
    end
    check({tag, "_busy_len"}, 32'(n), 32'(n_exp));
    e = sb.pop_front();
    check({e.tag, "_hi"}, bus.hi, e.hi);
    check({e.tag, "_lo"}, bus.lo, e.lo);
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] v);
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = v;
    tick();
    bus.start = 1'b0;
    bus.md_op = 3'd0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int stall_hi;
    tests = 0;
    fails = 0;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.md_op    = 3'd0;
    bus.rs_val   = 32'd0;
    bus.rt_val   = 32'd0;
    bus.md_use_d = 1'b0;
    #3;
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_stall", 32'(bus.md_stall), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // MTHI then MTLO: one-edge latency each, never busy.
    bus.start = 1'b1; bus.md_op = 3'(MD_MTHI); bus.rs_val = 32'hDEADBEEF;
    tick();
    check("mthi_hi", bus.hi, 32'hDEADBEEF);
    check("mthi_busy", 32'(bus.busy), 32'd0);
    bus.md_op = 3'(MD_MTLO); bus.rs_val = 32'h1;
    tick();
    bus.start = 1'b0; bus.md_op = 3'd0;
    check("mtlo_lo", bus.lo, 32'h1);
    check("mtlo_hi_keep", bus.hi, 32'hDEADBEEF);
    check("mtlo_busy", 32'(bus.busy), 32'd0);

    // Reset in the middle of a MULT clears state asynchronously and drops the result.
    bus.start = 1'b1; bus.md_op = 3'(MD_MULT); bus.rs_val = 32'd3; bus.rt_val = 32'd4;
    tick();
    bus.start = 1'b0; bus.md_op = 3'd0;
    check("rmid_busy_before", 32'(bus.busy), 32'd1);
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    check("rmid_busy", 32'(bus.busy), 32'd0);
    check("rmid_hi", bus.hi, 32'd0);
    check("rmid_lo", bus.lo, 32'd0);
    #2 reset = 1'b1;
    repeat (8) tick();
    check("rmid_late_hi", bus.hi, 32'd0);
    check("rmid_late_lo", bus.lo, 32'd0);

    run_op(3'(MD_MULT),  32'hFFFFFFFE, 32'd3,        "mult_s",   5,  32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op(3'(MD_MULTU), 32'hFFFFFFFF, 32'hFFFFFFFF, "multu",    5,  32'hFFFFFFFE, 32'h00000001);
    run_op(3'(MD_DIV),   32'hFFFFFFF9, 32'd2,        "div_s",    10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(3'(MD_DIV),   32'd7,        32'hFFFFFFFE, "div_s2",   10, 32'h00000001, 32'hFFFFFFFD);
    run_op(3'(MD_DIV),   32'h80000000, 32'hFFFFFFFF, "div_ovf",  10, 32'h00000000, 32'h80000000);
    run_op(3'(MD_DIVU),  32'd100,      32'd7,        "divu",     10, 32'd2,        32'd14);
    run_op(3'(MD_DIVU),  32'hFFFFFFF9, 32'd2,        "divu_big", 10, 32'h00000001, 32'h7FFFFFFC);

    mt(3'(MD_MTHI), 32'h11);
    mt(3'(MD_MTLO), 32'h22);
    run_op(3'(MD_DIVU),  32'd5,        32'd0,        "divu_z",   10, 32'h11,       32'h22);
    run_op(3'(MD_DIV),   32'd5,        32'd0,        "div_z",    10, 32'h11,       32'h22);

    // Stall window: start cycle plus every busy cycle; a start during busy is ignored.
    stall_hi = 0;
    bus.md_use_d = 1'b1;
    bus.start = 1'b1; bus.md_op = 3'(MD_MULTU); bus.rs_val = 32'h00010000; bus.rt_val = 32'h00010000;
    #1;
    check("stall_start_cycle", 32'(bus.md_stall), 32'd1);
    if (bus.md_stall) stall_hi++;
    tick();
    bus.start = 1'b0; bus.md_op = 3'd0;
    n = 0;
    while (bus.busy && n < 64) begin
      if (bus.md_stall) stall_hi++;
      n++;
      if (n == 2) begin
        bus.start = 1'b1; bus.md_op = 3'(MD_MTHI); bus.rs_val = 32'h999;
      end else begin
        bus.start = 1'b0; bus.md_op = 3'd0;
      end
      tick();
    end
    bus.start = 1'b0; bus.md_op = 3'd0;
    #1;
    check("stall_busy_len", 32'(n), 32'd5);
    check("stall_cycles", 32'(stall_hi), 32'd6);
    check("stall_after", 32'(bus.md_stall), 32'd0);
    check("stall_hi", bus.hi, 32'h1);
    check("stall_lo", bus.lo, 32'h0);
    bus.md_use_d = 1'b0;

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the 5-stage MIPS pipeline. It sits in the E stage beside the ALU and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations decoded from the instruction fields. It sequences a fixed-latency operation with a busy counter, owns the HI/LO architectural registers, and raises the stall request the hazard unit uses to hold D-stage MDU instructions.

## Interface
- MULT_CYCLES, default 5: busy cycles for MULT/MULTU.
- DIV_CYCLES, default 10: busy cycles for DIV/DIVU.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset. Clears all state immediately on assertion.
- start  input  1  E stage holds a valid MDU operation this cycle.
- md_op  input  3  operation code (see Operation).
- rs_val  input  32  forwarded GPR[rs] operand.
- rt_val  input  32  forwarded GPR[rt] operand.
- md_use_d  input  1  D-stage instruction is MDU-related: mult/div/mthi/mtlo/mfhi/mflo.
- busy  output  1  an operation is in flight.
- md_stall  output  1  stall request to the hazard unit; equals (start | busy) & md_use_d.
- hi  output  32  HI register.
- lo  output  32  LO register.

## Operation
- md_op encoding: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO. Codes 7 and NONE are no-ops.
- IDLE (cnt==0): when start is high at a rising edge:
  - MULT/MULTU/DIV/DIVU: compute the result from rs_val and rt_val into pending registers p_hi/p_lo. Load cnt with MULT_CYCLES or DIV_CYCLES.
  - MTHI: hi<=rs_val in the same edge, no busy.
  - MTLO: lo<=rs_val in the same edge, no busy.
- BUSY (cnt!=0): cnt decrements by 1 each edge. On the edge where cnt==1, hi<=p_hi, lo<=p_lo and cnt becomes 0.
- start while busy is ignored entirely, including MTHI/MTLO. The hazard unit guarantees this does not occur; md_stall prevents it.
- MULT: {hi,lo} = signed 32x32 to 64-bit product. MULTU: same, unsigned.
- DIV: lo = quotient truncated toward zero, hi = remainder with the dividend's sign. DIVU: same, unsigned.
- DIV/DIVU with rt_val==0: the busy sequence runs normally, but hi/lo keep their prior values at completion.
- DIV with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This must not trap or produce X.
- busy = (cnt != 0), driven from the register, not combinationally from start.

## Timing
- Reset values: hi=0, lo=0, cnt=0, p_hi=0, p_lo=0, busy=0. md_stall is 0 unless start&md_use_d.
- For an operation sampled at edge T with latency N:
  - busy is high from after T through after T+N-1, i.e. N cycles.
  - New hi/lo are visible after edge T+N, the same edge where busy falls.
- An MFHI/MFLO issued in the cycle after busy falls reads the new value.
- MTHI/MTLO have 1-edge latency; hi/lo are updated after the sampling edge.
- Reset asserted mid-operation aborts it: cnt=0 and hi/lo=0 asynchronously. The pending result is never written.
- md_stall is combinational and is valid in the same cycle start is asserted. This covers the cycle before busy rises.

## Structure
- Shared package mdu_pkg: md_op encodings MD_NONE..MD_MTLO, the default latencies, and the 3-bit opcode width constant.
- Sub-module mdu_arith: purely combinational. Inputs md_op, rs_val, rt_val. Outputs res_hi, res_lo, and div_zero. Holds the signed/unsigned multiply and divide, including the overflow and zero cases.
- mdu_ctrl holds the counter, the pending registers, HI/LO, and the stall logic.

## Test plan
- Reset mid-op: start MULT 3*4, assert reset at cycle 3 -> hi=lo=0, busy=0 immediately; no later write.
- MULT signed: rs=0xFFFFFFFE, rt=3, start at edge T -> busy high 5 cycles; after T+5, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV signed: rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU by zero: hi=0x11, lo=0x22 preloaded via MTHI/MTLO, then DIVU rs=5, rt=0 -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- Stall: MULTU in E with md_use_d=1 (MFLO in D) -> md_stall=1 for the start cycle plus 5 busy cycles, then 0. A second start during busy leaves hi/lo and cnt unaffected.
- MTHI/MTLO: MTHI rs=0xDEADBEEF, next cycle MTLO rs=0x1 -> hi=0xDEADBEEF after the first edge, lo=0x1 after the second; busy stays 0.
